ds1302_read: RTL and testbench
==============================

DS1302_READ -- requirements
Module: ds1302_read

Interface
REQ-001 Parameter: FORCE_RD, 1, when 1 the command byte transmitted is {addr[7:1],1'b1}; when 0 addr is sent unmodified.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  single-cycle read request, honoured only in IDLE.
REQ-005 addr  input  8  DS1302 command/address byte, latched when en is accepted.
REQ-006 sclk  input  1  serial clock from the shared SCLK generator, synchronous to clk.
REQ-007 dataIn  input  1  DS1302 I/O line as read back from the pad.
REQ-008 ce  output  1  DS1302 chip enable.
REQ-009 dataOut  output  1  serial command bit driven onto the I/O line, LSB first.
REQ-010 ioDir  output  1  pad direction: 1 = block drives I/O, 0 = I/O released to DS1302.
REQ-011 rdData  output  8  received data byte, LSB first on the wire.
REQ-012 done  output  1  one-clk pulse marking a completed read.

Function
REQ-013 sclk SHALL be registered once (sclkPrev); rise = sclk & ~sclkPrev, fall = ~sclk & sclkPrev, both one-clk strobes.
REQ-014 States SHALL be IDLE, SEND_CMD, RECV_DATA, FINISH.
REQ-015 IDLE: ce=0, ioDir=1, dataOut=0, done=0; en=1 latches the command byte, clears bitCnt, sets ce=1, dataOut=cmd[0], moves to SEND_CMD next clk.
REQ-016 SEND_CMD: on each rise bitCnt increments; on each fall after rises 1..7 dataOut = cmd[bitCnt]; bitCnt is 0..7 and counts 8 rises.
REQ-017 SEND_CMD -> RECV_DATA on the fall following the 8th rise; same clk: ioDir=0, bitCnt cleared.
REQ-018 RECV_DATA: on each rise the shift register samples dataIn into bit position bitCnt, then bitCnt increments; after the 8th sample (16th sclk rise overall) move to FINISH.
REQ-019 FINISH: one clk; rdData loaded from the shift register, done=1, ce=0, ioDir=1, dataOut=0; then IDLE.
REQ-020 rdData SHALL change only in FINISH and hold its value otherwise.
REQ-021 en outside IDLE SHALL be ignored, not queued.
REQ-022 sclk edges in IDLE or FINISH SHALL have no effect.
REQ-023 A rise and a fall can never be flagged in the same clk; no special handling is needed.
REQ-024 Latency: done SHALL assert exactly 1 clk after the clk that flags the 16th sclk rise following acceptance.

Reset
REQ-025 While rst=1: state=IDLE, ce=0, ioDir=1, dataOut=0, done=0, rdData=0x00, bitCnt=0, sclkPrev=0.
REQ-026 rst asserted mid-transfer SHALL abort in 1 clk with no done pulse; the next en SHALL start a clean transfer.

Structure
REQ-027 Package ds1302_pkg SHALL hold the state encoding, CMD_BITS=8, DATA_BITS=8 and RD_BIT_POS=0, shared with ds1302write.
REQ-028 One sub-module, sclk_edge_detect (sclk in, rise/fall out), SHALL be instantiated; it is shared with ds1302write.

Verification
REQ-029 Test 1: en with addr=0x81; DS1302 model returns 0x59 -> dataOut sequence 1,0,0,0,0,0,0,1; ioDir falls after the 8th sclk fall; rdData=0x59; done is high for exactly 1 clk; ce=0 afterwards.
REQ-030 Test 2: FORCE_RD=1, addr=0x80 -> command on wire is 0x81; FORCE_RD=0, addr=0x80 -> command on wire is 0x80.
REQ-031 Test 3: second en pulsed during RECV_DATA -> exactly one done pulse, rdData is from the first read only, no restart.
REQ-032 Test 4: rst for 1 clk after the 11th sclk rise -> next clk ce=0, ioDir=1, no done; a following read of a model returning 0xA5 gives rdData=0xA5.
REQ-033 Test 5: 20 sclk pulses with en=0 -> ce, dataOut, done stay 0, ioDir stays 1, rdData unchanged.
REQ-034 Test 6: back-to-back reads returning 0x00 then 0xFF -> rdData 0x00 then 0xFF, two done pulses.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 serial read/write blocks.
// Holds the transfer state encoding, field widths and command helper.
package ds1302_pkg;

    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 8;
    localparam int RD_BIT_POS = 0;
    localparam int CNT_W      = $clog2(CMD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_RECV_DATA,
        ST_FINISH
    } ds1302_state_e;

    // Command byte as put on the wire; optionally forces the read bit.
    function automatic logic [CMD_BITS-1:0] cmd_byte(
        input logic [CMD_BITS-1:0] addr,
        input bit                  force_rd
    );
        logic [CMD_BITS-1:0] c;
        c = addr;
        if (force_rd) begin
            c[RD_BIT_POS] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/ds1302_read_sclk_edge_detect.sv
// Edge strobes for the shared SCLK generator output.
// sclk is already synchronous to clk, so one register suffices.
module sclk_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    output logic rise,
    output logic fall
);

    logic sclk_prev_q;
    logic sclk_prev_d;

    // Next value of the delayed copy of sclk.
    always_comb begin
        sclk_prev_d = sclk;
    end

    // Delay register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign rise = sclk & ~sclk_prev_q;
    assign fall = ~sclk & sclk_prev_q;

endmodule

// File: rtl/ds1302_read.sv
// DS1302 single-byte read: sends a command byte LSB first,
// then releases the I/O line and shifts in one data byte.
module ds1302_read
    import ds1302_pkg::*;
#(
    parameter bit FORCE_RD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CMD_BITS-1:0]  addr,
    input  logic                 sclk,
    input  logic                 dataIn,
    output logic                 ce,
    output logic                 dataOut,
    output logic                 ioDir,
    output logic [DATA_BITS-1:0] rdData,
    output logic                 done
);

    logic rise;
    logic fall;

    sclk_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

    ds1302_state_e        state_q,    state_d;
    logic [CMD_BITS-1:0]  cmd_q,      cmd_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [DATA_BITS-1:0] rd_data_q,  rd_data_d;
    logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic                 cmd_sent_q, cmd_sent_d;
    logic                 ce_q,       ce_d;
    logic                 dout_q,     dout_d;
    logic                 io_dir_q,   io_dir_d;
    logic                 done_q,     done_d;

    // Next state; pin values are computed for the state being entered
    // so the registered outputs line up with the visible state.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        shreg_d    = shreg_q;
        rd_data_d  = rd_data_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sent_d = cmd_sent_q;
        ce_d       = ce_q;
        dout_d     = dout_q;
        io_dir_d   = io_dir_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ce_d     = 1'b0;
                io_dir_d = 1'b1;
                dout_d   = 1'b0;
                if (en) begin
                    cmd_d      = cmd_byte(addr, FORCE_RD);
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    cmd_sent_d = 1'b0;
                    ce_d       = 1'b1;
                    dout_d     = cmd_d[0];
                    state_d    = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        cmd_sent_d = 1'b1;
                    end
                end else if (fall) begin
                    if (cmd_sent_q) begin
                        io_dir_d   = 1'b0;
                        bit_cnt_d  = '0;
                        cmd_sent_d = 1'b0;
                        state_d    = ST_RECV_DATA;
                    end else begin
                        dout_d = cmd_q[bit_cnt_q];
                    end
                end
            end
            ST_RECV_DATA: begin
                if (rise) begin
                    shreg_d[bit_cnt_q] = dataIn;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        rd_data_d = shreg_d;
                        done_d    = 1'b1;
                        ce_d      = 1'b0;
                        io_dir_d  = 1'b1;
                        dout_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            shreg_q    <= '0;
            rd_data_q  <= '0;
            bit_cnt_q  <= '0;
            cmd_sent_q <= 1'b0;
            ce_q       <= 1'b0;
            dout_q     <= 1'b0;
            io_dir_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            shreg_q    <= shreg_d;
            rd_data_q  <= rd_data_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sent_q <= cmd_sent_d;
            ce_q       <= ce_d;
            dout_q     <= dout_d;
            io_dir_q   <= io_dir_d;
            done_q     <= done_d;
        end
    end

    assign ce      = ce_q;
    assign dataOut = dout_q;
    assign ioDir   = io_dir_q;
    assign rdData  = rd_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ds1302_read.sv
// Directed bench for ds1302_read, one instance per FORCE_RD value.
// Both instances see identical stimulus and a shared DS1302 model.
module tb_ds1302_read;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] addr;
    logic       sclk;
    logic       data_in;

    logic       ce1, dout1, dir1, done1;
    logic [7:0] rd1;
    logic       ce0, dout0, dir0, done0;
    logic [7:0] rd0;

    int n_pass  = 0;
    int n_total = 0;
    int d1_cnt  = 0;
    int d0_cnt  = 0;

    always #5 clk = ~clk;

    ds1302_read #(.FORCE_RD(1'b1)) u_rd1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .addr    (addr),
        .sclk    (sclk),
        .dataIn  (data_in),
        .ce      (ce1),
        .dataOut (dout1),
        .ioDir   (dir1),
        .rdData  (rd1),
        .done    (done1)
    );

    ds1302_read #(.FORCE_RD(1'b0)) u_rd0 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .addr    (addr),
        .sclk    (sclk),
        .dataIn  (data_in),
        .ce      (ce0),
        .dataOut (dout0),
        .ioDir   (dir0),
        .rdData  (rd0),
        .done    (done0)
    );

    // Count done pulses in clk cycles (a 2-cycle pulse counts twice).
    always @(negedge clk) begin
        if (done1 === 1'b1) d1_cnt++;
        if (done0 === 1'b1) d0_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // One read transaction; the bench is the DS1302: it samples the
    // command on sclk rise and presents data bits ahead of each rise.
    task automatic do_read(input  logic [7:0] a,
                           input  logic [7:0] dbyte,
                           input  int         mid_en,
                           input  int         abort_at,
                           output logic [7:0] c1,
                           output logic [7:0] c0,
                           output logic [1:0] dir_pre,
                           output logic [1:0] dir_post);
        c1 = '0;
        c0 = '0;
        dir_pre  = '0;
        dir_post = '0;
        @(negedge clk);
        en   = 1'b1;
        addr = a;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i >= 8) data_in = dbyte[i-8];
            if (i < 8) begin
                c1[i] = dout1;
                c0[i] = dout0;
            end
            sclk = 1'b1;
            if (i == mid_en) en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            if (i + 1 == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst  = 1'b0;
                sclk = 1'b0;
                return;
            end
            if (i == 7) dir_pre = {dir1, dir0};
            sclk = 1'b0;
            repeat (2) @(negedge clk);
            if (i == 7) dir_post = {dir1, dir0};
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] model;
        logic [7:0] cmd1;
        logic [7:0] cmd0;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] c1, c0;
    logic [1:0] dpre, dpost;
    int         b1, b0;
    logic       bad;

    initial begin
        vecs[0] = '{8'h81, 8'h59, 8'h81, 8'h81};
        vecs[1] = '{8'h80, 8'h3C, 8'h81, 8'h80};
        vecs[2] = '{8'h00, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{8'hFE, 8'hFF, 8'hFF, 8'hFE};
        vecs[4] = '{8'hC1, 8'h96, 8'hC1, 8'hC1};

        rst     = 1'b1;
        en      = 1'b0;
        addr    = 8'h00;
        sclk    = 1'b0;
        data_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce", {ce1, ce0}, 2'b00);
        check("rst_dir", {dir1, dir0}, 2'b11);
        check("rst_dout", {dout1, dout0}, 2'b00);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_rd1", rd1, 8'h00);
        check("rst_rd0", rd0, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            b1 = d1_cnt;
            b0 = d0_cnt;
            do_read(vecs[v].addr, vecs[v].model, -1, -1,
                    c1, c0, dpre, dpost);
            @(negedge clk);
            check($sformatf("v%0d_cmd1", v), c1, vecs[v].cmd1);
            check($sformatf("v%0d_cmd0", v), c0, vecs[v].cmd0);
            check($sformatf("v%0d_rd1", v), rd1, vecs[v].model);
            check($sformatf("v%0d_rd0", v), rd0, vecs[v].model);
            check($sformatf("v%0d_done1", v), d1_cnt - b1, 1);
            check($sformatf("v%0d_done0", v), d0_cnt - b0, 1);
            check($sformatf("v%0d_ce", v), {ce1, ce0}, 2'b00);
            check($sformatf("v%0d_dirpre", v), dpre, 2'b11);
            check($sformatf("v%0d_dirpost", v), dpost, 2'b00);
        end

        // en during RECV_DATA is dropped, not queued.
        b1 = d1_cnt;
        do_read(8'h81, 8'h3A, 10, -1, c1, c0, dpre, dpost);
        repeat (6) @(negedge clk);
        check("miden_done", d1_cnt - b1, 1);
        check("miden_rd", rd1, 8'h3A);
        check("miden_ce", {ce1, ce0}, 2'b00);

        // sclk activity while idle does nothing.
        b1  = d1_cnt;
        bad = 1'b0;
        for (int p = 0; p < 20; p++) begin
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            bad |= ce1 | ce0 | dout1 | dout0 | ~dir1 | ~dir0;
            sclk = 1'b0;
            repeat (2) @(negedge clk);
            bad |= ce1 | ce0 | dout1 | dout0 | ~dir1 | ~dir0;
        end
        check("idle_pins", bad, 1'b0);
        check("idle_done", d1_cnt - b1, 0);
        check("idle_rd", rd1, 8'h3A);

        // Reset after the 11th sclk rise aborts without done.
        b1 = d1_cnt;
        do_read(8'h81, 8'h77, -1, 11, c1, c0, dpre, dpost);
        check("abort_ce", {ce1, ce0}, 2'b00);
        check("abort_dir", {dir1, dir0}, 2'b11);
        check("abort_rd", rd1, 8'h00);
        repeat (4) @(negedge clk);
        check("abort_done", d1_cnt - b1, 0);

        b1 = d1_cnt;
        do_read(8'h81, 8'hA5, -1, -1, c1, c0, dpre, dpost);
        @(negedge clk);
        check("post_abort_cmd", c1, 8'h81);
        check("post_abort_rd1", rd1, 8'hA5);
        check("post_abort_rd0", rd0, 8'hA5);
        check("post_abort_done", d1_cnt - b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
